// File: rtl/relu_pool_ctrl.sv
// relu_pool_ctrl: ReLU + 2x2 max-pool sequencer over a single-port feature SRAM.
//
// For every output (oy outer, ox, c inner) it reads the four window taps from the
// feature SRAM, clamps negatives to zero and keeps the running maximum. The pooled
// value is then offered on a valid/ready write port. An odd trailing row or column
// of the input map is never read.
//
// Optional feature: define RELU_POOL_NEG_CNT_EN to add neg_count, a count of the
// negative taps seen in the current/most recent pass.
//
// Ports:
//   clk, rst   clock, synchronous active-high reset
//   start      one-cycle pulse, begins a pass (only honoured in idle)
//   busy       high from the cycle after an accepted start through the done cycle
//   done       one-cycle pulse at the end of a pass
//   rd_en      feature SRAM read strobe
//   rd_addr    feature SRAM address, (y*WIDTH + x)*CHANNELS + c
//   rd_data    read data, valid one cycle after rd_en
//   wr_valid   pooled result valid
//   wr_ready   sink ready; transfer when wr_valid && wr_ready
//   wr_addr    pooled address, (oy*(WIDTH/2) + ox)*CHANNELS + c
//   wr_data    pooled value (never negative)
//   neg_count  negative-tap counter (RELU_POOL_NEG_CNT_EN only)
module relu_pool_ctrl #(
    parameter int WIDTH    = 28,
    parameter int HEIGHT   = 28,
    parameter int CHANNELS = 16,
    parameter int DW       = 18,
    parameter int RA_W     = $clog2(WIDTH * HEIGHT * CHANNELS),
    parameter int WA_W     = $clog2((WIDTH / 2) * (HEIGHT / 2) * CHANNELS)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    output logic            busy,
    output logic            done,
    output logic            rd_en,
    output logic [RA_W-1:0] rd_addr,
    input  logic [DW-1:0]   rd_data,
    output logic            wr_valid,
    input  logic            wr_ready,
    output logic [WA_W-1:0] wr_addr,
`ifdef RELU_POOL_NEG_CNT_EN
    output logic [31:0]     neg_count,
`endif
    output logic [DW-1:0]   wr_data
);

    localparam int OW = WIDTH / 2;
    localparam int OH = HEIGHT / 2;
    localparam int XW = (OW > 1) ? $clog2(OW) : 1;
    localparam int YW = (OH > 1) ? $clog2(OH) : 1;
    localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

    typedef enum logic [2:0] {StIdle, StRead, StDrain, StWrite, StDone} state_e;

    state_e        state_q, state_d;
    logic [1:0]    tap_q;
    logic [XW-1:0] ox_q;
    logic [YW-1:0] oy_q;
    logic [CW-1:0] ch_q;
    logic          cap_vld_q, cap_first_q;
    logic [DW-1:0] acc_q;
    logic [DW-1:0] relu_val;
    logic          last_c, last_x, last_y, last_out, hs;
    logic [31:0]   py, px;

    assign last_c   = (ch_q == CW'(CHANNELS - 1));
    assign last_x   = (ox_q == XW'(OW - 1));
    assign last_y   = (oy_q == YW'(OH - 1));
    assign last_out = last_c && last_x && last_y;
    assign hs       = wr_valid && wr_ready;
    assign relu_val = rd_data[DW-1] ? '0 : rd_data;

    // State register
    always_ff @(posedge clk) begin
        if (rst) state_q <= StIdle;
        else     state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (start) state_d = StRead;
            StRead:  if (tap_q == 2'd3) state_d = StDrain;
            StDrain: state_d = StWrite;
            StWrite: if (wr_ready) state_d = last_out ? StDone : StRead;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Outputs
    always_comb begin
        busy     = (state_q != StIdle);
        done     = (state_q == StDone);
        rd_en    = (state_q == StRead);
        wr_valid = (state_q == StWrite);
        // Tap bit 1 selects the lower row, bit 0 the right column of the window.
        py       = 2 * 32'(oy_q) + 32'(tap_q[1]);
        px       = 2 * 32'(ox_q) + 32'(tap_q[0]);
        rd_addr  = RA_W'((py * WIDTH + px) * CHANNELS + 32'(ch_q));
        wr_addr  = WA_W'((32'(oy_q) * OW + 32'(ox_q)) * CHANNELS + 32'(ch_q));
        wr_data  = acc_q;
    end

    // Tap counter; wraps to 0 after the fourth read
    always_ff @(posedge clk) begin
        if (rst)                    tap_q <= 2'd0;
        else if (state_q == StRead) tap_q <= tap_q + 2'd1;
        else                        tap_q <= 2'd0;
    end

    // Capture pipeline: rd_data belongs to the read issued one cycle earlier.
    // Both operands are non-negative after ReLU, so an unsigned compare suffices.
    always_ff @(posedge clk) begin
        if (rst) begin
            cap_vld_q   <= 1'b0;
            cap_first_q <= 1'b0;
            acc_q       <= '0;
        end else begin
            cap_vld_q   <= rd_en;
            cap_first_q <= rd_en && (tap_q == 2'd0);
            if (cap_vld_q && (cap_first_q || (relu_val > acc_q))) acc_q <= relu_val;
        end
    end

    // Output indices advance only on a write handshake; cleared after the last one
    always_ff @(posedge clk) begin
        if (rst) begin
            ox_q <= '0;
            oy_q <= '0;
            ch_q <= '0;
        end else if (hs) begin
            if (last_out) begin
                ox_q <= '0;
                oy_q <= '0;
                ch_q <= '0;
            end else if (!last_c) begin
                ch_q <= ch_q + CW'(1);
            end else begin
                ch_q <= '0;
                if (!last_x) begin
                    ox_q <= ox_q + XW'(1);
                end else begin
                    ox_q <= '0;
                    oy_q <= oy_q + YW'(1);
                end
            end
        end
    end

`ifdef RELU_POOL_NEG_CNT_EN
    logic [31:0] neg_q;

    always_ff @(posedge clk) begin
        if (rst)                                neg_q <= '0;
        else if ((state_q == StIdle) && start)  neg_q <= '0;
        else if (cap_vld_q && rd_data[DW-1])    neg_q <= neg_q + 32'd1;
    end

    assign neg_count = neg_q;
`endif

endmodule

// File: tb/tb_relu_pool_ctrl.sv
// Scoreboard bench for relu_pool_ctrl on a 4x4 map with 2 channels.
module tb_relu_pool_ctrl;

    localparam int W    = 4;
    localparam int H    = 4;
    localparam int C    = 2;
    localparam int DW   = 18;
    localparam int RA_W = $clog2(W * H * C);
    localparam int WA_W = $clog2((W / 2) * (H / 2) * C);

    logic            clk;
    logic            rst;
    logic            start;
    logic            busy, done, rd_en, wr_valid, wr_ready;
    logic [RA_W-1:0] rd_addr;
    logic [DW-1:0]   rd_data;
    logic [WA_W-1:0] wr_addr;
    logic [DW-1:0]   wr_data;
`ifdef RELU_POOL_NEG_CNT_EN
    logic [31:0]     neg_count;
`endif

    relu_pool_ctrl #(
        .WIDTH   (W),
        .HEIGHT  (H),
        .CHANNELS(C),
        .DW      (DW)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .busy     (busy),
        .done     (done),
        .rd_en    (rd_en),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data),
        .wr_valid (wr_valid),
        .wr_ready (wr_ready),
        .wr_addr  (wr_addr),
`ifdef RELU_POOL_NEG_CNT_EN
        .neg_count(neg_count),
`endif
        .wr_data  (wr_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Feature SRAM model, one-cycle read latency
    logic [DW-1:0] mem [W*H*C];
    always @(posedge clk) if (rd_en) rd_data <= mem[rd_addr];

    typedef struct packed {
        logic [WA_W-1:0] a;
        logic [DW-1:0]   d;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   exp_neg  = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] relu(input logic [DW-1:0] v);
        return v[DW-1] ? '0 : v;
    endfunction

    // Expected pooled outputs for the current memory image, in sink order
    task automatic build_sb();
        exp_t e;
        logic [DW-1:0] v, r, m;
        sb.delete();
        exp_neg = 0;
        for (int oy = 0; oy < H / 2; oy++)
            for (int ox = 0; ox < W / 2; ox++)
                for (int c = 0; c < C; c++) begin
                    m = '0;
                    for (int t = 0; t < 4; t++) begin
                        v = mem[((2 * oy + t / 2) * W + 2 * ox + t % 2) * C + c];
                        if (v[DW-1]) exp_neg++;
                        r = relu(v);
                        if (r > m) m = r;
                    end
                    e.a = WA_W'((oy * (W / 2) + ox) * C + c);
                    e.d = m;
                    sb.push_back(e);
                end
    endtask

    // One pass: optional stall of the 2nd output, optional reset during the 2nd READ
    task automatic run_pass(input int exp_cycles, input int stall_n, input bit abort,
                            input string name);
        int k = 0;
        int hs = 0;
        int stall_left = stall_n;
        logic [WA_W-1:0] held_a = '0;
        logic [DW-1:0]   held_d = '0;
        exp_t e;
        build_sb();
        @(posedge clk); #1;
        start    = 1'b1;
        wr_ready = 1'b1;
        while (k < 300) begin
            @(posedge clk); #1;
            k++;
            start = (k == 10);  // mid-pass start must be ignored
            if (k == 1) begin
                check_eq({name, "_busy1"}, 32'(busy), 32'd1);
                check_eq({name, "_rden1"}, 32'(rd_en), 32'd1);
                check_eq({name, "_rdaddr1"}, 32'(rd_addr), 32'd0);
`ifdef RELU_POOL_NEG_CNT_EN
                check_eq({name, "_negclr"}, neg_count, 32'd0);
`endif
            end
            if (abort && hs == 1 && rd_en) begin
                rst = 1'b1;
                @(posedge clk); #1;
                rst = 1'b0;
                check_eq({name, "_rst_rden"}, 32'(rd_en), 32'd0);
                check_eq({name, "_rst_wrvalid"}, 32'(wr_valid), 32'd0);
                check_eq({name, "_rst_busy"}, 32'(busy), 32'd0);
                @(posedge clk); #1;
                check_eq({name, "_rst_idle"}, 32'(busy | rd_en), 32'd0);
                sb.delete();
                return;
            end
            if (wr_valid && hs == 1 && stall_left > 0) begin
                if (stall_left == stall_n) begin
                    held_a = wr_addr;
                    held_d = wr_data;
                end else begin
                    check_eq({name, "_held_addr"}, 32'(wr_addr), 32'(held_a));
                    check_eq({name, "_held_data"}, 32'(wr_data), 32'(held_d));
                end
                check_eq({name, "_stall_rden"}, 32'(rd_en), 32'd0);
                wr_ready = 1'b0;
                stall_left--;
            end else begin
                wr_ready = 1'b1;
            end
            if (wr_valid && wr_ready) begin
                if (sb.size() == 0) begin
                    check_eq({name, "_extra_write"}, 32'(wr_addr), 32'hffff_ffff);
                end else begin
                    e = sb.pop_front();
                    check_eq({name, "_wr_addr"}, 32'(wr_addr), 32'(e.a));
                    check_eq({name, "_wr_data"}, 32'(wr_data), 32'(e.d));
                end
                hs++;
            end
            if (done) break;
        end
        check_eq({name, "_cycles"}, 32'(k), 32'(exp_cycles));
        check_eq({name, "_sb_left"}, 32'(sb.size()), 32'd0);
`ifdef RELU_POOL_NEG_CNT_EN
        check_eq({name, "_neg"}, neg_count, 32'(exp_neg));
`endif
        // start coinciding with done is not accepted
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check_eq({name, "_post_busy"}, 32'(busy), 32'd0);
        check_eq({name, "_post_done"}, 32'(done), 32'd0);
`ifdef RELU_POOL_NEG_CNT_EN
        check_eq({name, "_neg_hold"}, neg_count, 32'(exp_neg));
`endif
    endtask

    initial begin
        rst      = 1'b1;
        start    = 1'b0;
        wr_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_done", 32'(done), 32'd0);
        check_eq("rst_rden", 32'(rd_en), 32'd0);
        check_eq("rst_wrvalid", 32'(wr_valid), 32'd0);
        check_eq("rst_rdaddr", 32'(rd_addr), 32'd0);
        check_eq("rst_wraddr", 32'(wr_addr), 32'd0);
        check_eq("rst_wrdata", 32'(wr_data), 32'd0);
`ifdef RELU_POOL_NEG_CNT_EN
        check_eq("rst_neg", neg_count, 32'd0);
`endif
        rst = 1'b0;

        // Ramp in channel 0, its negation in channel 1
        for (int i = 0; i < W * H; i++) begin
            mem[i * C]     = DW'(i);
            mem[i * C + 1] = DW'(-i);
        end
        run_pass(6 * 8 + 1, 0, 1'b0, "ramp");

        // Random map with all-negative and extreme-value windows in channel 0
        for (int i = 0; i < W * H * C; i++) mem[i] = DW'($urandom);
        mem[(0 * W + 0) * C] = 18'h3FFFD;
        mem[(0 * W + 1) * C] = 18'h3FFFF;
        mem[(1 * W + 0) * C] = 18'h3FFF9;
        mem[(1 * W + 1) * C] = 18'h3FFFE;
        mem[(0 * W + 2) * C] = 18'h1FFFF;
        mem[(0 * W + 3) * C] = 18'h00000;
        mem[(1 * W + 2) * C] = 18'h20000;
        mem[(1 * W + 3) * C] = 18'h00005;
        run_pass(6 * 8 + 1 + 3, 3, 1'b0, "stall");

        run_pass(0, 0, 1'b1, "abort");
        run_pass(6 * 8 + 1, 0, 1'b0, "restart");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
